rsa256_host_if: RTL
===================

// Module: rsa256_host_if
// PURPOSE
// Host-side counterpart of the RSA256 core: the initiator on its src handshake and the responder on its result handshake.
// - Receives a byte stream: key N (32 B), exponent E (32 B), then an endless sequence of 32-byte ciphertext blocks.
// - Assembles each field MSB-first and presents {a,e,n} to the core on o_src_val/i_src_rdy.
// - Captures each decoded result and streams its low 248 bits back as 31 bytes, MSB-first.
// PARAMETERS
// WIDTH      256  operand width in bits; must be a multiple of 8
// IN_BYTES   32   bytes per received field (WIDTH/8)
// OUT_BYTES  31   bytes sent per result; the low OUT_BYTES*8 bits of the result are sent
// PORTS
// i_clk           in   1    clock, rising edge
// i_rst           in   1    reset, asynchronous, active-high
// i_rx_data       in   8    incoming byte
// i_rx_val        in   1    incoming byte valid
// o_rx_rdy        out  1    block accepts a byte; transfer when i_rx_val & o_rx_rdy
// o_tx_data       out  8    outgoing byte
// o_tx_val        out  1    outgoing byte valid
// i_tx_rdy        in   1    sink accepts a byte; transfer when o_tx_val & i_tx_rdy
// o_src_val       out  1    {o_a,o_e,o_n} valid to the core
// i_src_rdy       in   1    core has taken the operands
// o_a             out  WIDTH  ciphertext block
// o_e             out  WIDTH  exponent
// o_n             out  WIDTH  modulus
// i_result_val    in   1    core result valid (may be a single-cycle pulse)
// o_result_rdy    out  1    result accepted
// i_result        in   WIDTH  a^e mod n
// o_busy          out  1    high in every state except RX_N
// BEHAVIOUR
// - Reset: state = RX_N; byte counter = 0; o_a/o_e/o_n/result register = 0.
//   All outputs at reset: o_rx_rdy = 1, o_tx_val = 0, o_src_val = 0, o_result_rdy = 0, o_tx_data = 0, o_busy = 0.
// - States: RX_N -> RX_E -> RX_A -> REQ -> WAIT_RES -> TX -> RX_A (loop). N and E are kept until the next reset.
// - RX_N / RX_E / RX_A:
//   - o_rx_rdy = 1; every accepted byte shifts in: field <= {field[WIDTH-9:0], i_rx_data}.
//   - The counter increments per accepted byte. On the IN_BYTES-th byte, counter -> 0 and the FSM advances.
//   - No acceptance in any other state (o_rx_rdy = 0).
// - REQ:
//   - o_src_val is registered high on entry; o_a/o_e/o_n are held stable.
//   - When i_src_rdy is sampled high, move to WAIT_RES; o_src_val is low from the next cycle.
//   - Latency from the last A byte accepted to o_src_val high is 1 cycle.
// - WAIT_RES:
//   - Always ready. On any cycle i_result_val = 1, latch i_result, pulse o_result_rdy high for exactly 1 cycle (registered), go to TX.
//   - i_result_val outside WAIT_RES is ignored.
// - TX:
//   - o_tx_val = 1; o_tx_data = result[OUT_BYTES*8-1 -: 8] of the shifting result register.
//   - On each o_tx_val & i_tx_rdy: shift left 8 bits and increment the counter.
//   - After byte OUT_BYTES is accepted: counter -> 0, o_tx_val = 0 the next cycle, state -> RX_A.
//   - o_tx_data is stable while i_tx_rdy = 0.
// - Simultaneous rx/tx: impossible by construction; rx and tx are never both ready/valid in the same cycle.
// - Bits above OUT_BYTES*8 of the result are discarded (result < n < 2^248 by protocol).
// - Counter width = $clog2(IN_BYTES)+1. Wrap is handled explicitly by the counter -> 0 assignments above, never by overflow.
// - Asynchronous reset mid-operation (any state, including during a transfer): all registers return to reset values immediately.
//   The host must resend N and E. A pending core handshake is abandoned; o_src_val drops at once.
// TESTING
// 1. Key load:
//    - Stimulus: send 31x00,8F (N=143); 31x00,07 (E=7); 31x00,02 (A=2).
//    - Required: o_src_val high 1 cycle after the last byte, with o_n=143, o_e=7, o_a=2.
// 2. Result path:
//    - Stimulus: stub core asserts i_src_rdy 3 cycles after o_src_val; 20 cycles later pulses i_result_val 1 cycle with i_result=128.
//    - Required: o_result_rdy pulses once; tx emits 30x00 then 80; then o_rx_rdy=1.
// 3. Back-pressure:
//    - Stimulus: i_rx_val gapped randomly; i_tx_rdy low for 5 cycles mid-result.
//    - Required: same bytes in the same order; o_tx_data held during stall.
// 4. Multiple blocks, no key reload:
//    - Stimulus: second A=0x03 after test 2.
//    - Required: o_e=7, o_n=143 unchanged; o_a=3.
//    - Stub result 42 -> tx 30x00,2A.
// 5. Reset mid-TX:
//    - Stimulus: assert i_rst after 10 tx bytes.
//    - Required: o_tx_val=0 immediately; state RX_N; o_busy=0; o_n=0; a new full key load then works.
// 6. Stray inputs:
//    - Stimulus: i_result_val pulse in RX_A; i_rx_val high during TX.
//    - Required: ignored; no o_result_rdy; o_rx_rdy=0, no byte absorbed.

Source files
------------

// File: rtl/rsa256_host_if.sv
// rsa256_host_if: host-side front end of the RSA256 core.
// Assembles N, E and a stream of ciphertext blocks from a byte stream
// (MSB-first), hands {a,e,n} to the core, then streams the low OUT_BYTES
// bytes of each result back out MSB-first.
//
// Ports:
//   i_clk, i_rst                      clock (rising edge), async active-high reset
//   i_rx_data/i_rx_val/o_rx_rdy       incoming byte stream
//   o_tx_data/o_tx_val/i_tx_rdy       outgoing byte stream
//   o_src_val/i_src_rdy, o_a/o_e/o_n  operand handshake to the core
//   i_result_val/o_result_rdy/i_result  result handshake from the core
//   o_busy                            high in every state except RX_N
module rsa256_host_if #(
    parameter int unsigned WIDTH     = 256,
    parameter int unsigned IN_BYTES  = WIDTH / 8,
    parameter int unsigned OUT_BYTES = 31
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [7:0]       i_rx_data,
    input  logic             i_rx_val,
    output logic             o_rx_rdy,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_val,
    input  logic             i_tx_rdy,
    output logic             o_src_val,
    input  logic             i_src_rdy,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_e,
    output logic [WIDTH-1:0] o_n,
    input  logic             i_result_val,
    output logic             o_result_rdy,
    input  logic [WIDTH-1:0] i_result,
    output logic             o_busy
);

    localparam int unsigned CNT_W = $clog2(IN_BYTES) + 1;
    localparam int unsigned RES_W = OUT_BYTES * 8;

    typedef enum logic [2:0] {
        S_RX_N     = 3'd0,
        S_RX_E     = 3'd1,
        S_RX_A     = 3'd2,
        S_REQ      = 3'd3,
        S_WAIT_RES = 3'd4,
        S_TX       = 3'd5
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   n_q;
    logic [WIDTH-1:0]   e_q;
    logic [WIDTH-1:0]   a_q;
    logic [RES_W-1:0]   res_q;
    logic               result_rdy_q;

    logic               rx_fire;
    logic               tx_fire;
    logic               rx_last;
    logic               tx_last;

    // Result bits above RES_W are never transmitted (result < n < 2^RES_W).
    logic [WIDTH-RES_W-1:0] unused_res_hi;
    assign unused_res_hi = i_result[WIDTH-1:RES_W];

    assign rx_fire = i_rx_val & o_rx_rdy;
    assign tx_fire = o_tx_val & i_tx_rdy;
    assign rx_last = rx_fire && (cnt_q == CNT_W'(IN_BYTES - 1));
    assign tx_last = tx_fire && (cnt_q == CNT_W'(OUT_BYTES - 1));

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_RX_N;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RX_N:     if (rx_last)      state_d = S_RX_E;
            S_RX_E:     if (rx_last)      state_d = S_RX_A;
            S_RX_A:     if (rx_last)      state_d = S_REQ;
            S_REQ:      if (i_src_rdy)    state_d = S_WAIT_RES;
            S_WAIT_RES: if (i_result_val) state_d = S_TX;
            S_TX:       if (tx_last)      state_d = S_RX_A;
            default:                      state_d = S_RX_N;
        endcase
    end

    // Output decode from the state register
    always_comb begin
        o_rx_rdy     = 1'b0;
        o_tx_val     = 1'b0;
        o_src_val    = 1'b0;
        o_busy       = (state_q != S_RX_N);
        o_result_rdy = result_rdy_q;
        o_tx_data    = res_q[RES_W-1 -: 8];
        o_a          = a_q;
        o_e          = e_q;
        o_n          = n_q;
        case (state_q)
            S_RX_N, S_RX_E, S_RX_A: o_rx_rdy  = 1'b1;
            S_REQ:                  o_src_val = 1'b1;
            S_TX:                   o_tx_val  = 1'b1;
            default:                ;
        endcase
    end

    // Field shift registers, result register and byte counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q        <= '0;
            n_q          <= '0;
            e_q          <= '0;
            a_q          <= '0;
            res_q        <= '0;
            result_rdy_q <= 1'b0;
        end else begin
            result_rdy_q <= (state_q == S_WAIT_RES) && i_result_val;

            case (state_q)
                S_RX_N:     if (rx_fire) n_q <= {n_q[WIDTH-9:0], i_rx_data};
                S_RX_E:     if (rx_fire) e_q <= {e_q[WIDTH-9:0], i_rx_data};
                S_RX_A:     if (rx_fire) a_q <= {a_q[WIDTH-9:0], i_rx_data};
                S_WAIT_RES: if (i_result_val) res_q <= i_result[RES_W-1:0];
                S_TX:       if (tx_fire) res_q <= {res_q[RES_W-9:0], 8'h00};
                default:    ;
            endcase

            // Shared counter: rx and tx are never active in the same state
            if (rx_last || tx_last) begin
                cnt_q <= '0;
            end else if (rx_fire || tx_fire) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule
